pattern_tx_sched: RTL and testbench

- Round-robin scheduler that shares one 7-bit pattern generator between NREQ requesters in the optical-link simulation transmit path.
- Per job, it accepts a pattern and a repeat count from the winning requester and presents the pattern to the generator.
- It releases the generator's active-low reset for exactly reps*PAT_W cycles, then holds the generator in reset for a GAP-cycle guard interval.
- It pulses done when the job completes.

---
 rtl/pattern_tx_sched.sv | 119 +++++++++++
 tb/tb_pattern_tx_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx_sched.sv
// rtl/pattern_tx_sched.sv - round-robin scheduler sharing one pattern generator between requesters
module pattern_tx_sched #(
  parameter int NREQ  = 4,
  parameter int PAT_W = 7,
  parameter int CNT_W = 4,
  parameter int GAP   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*PAT_W-1:0]     req_pattern,
  input  logic [NREQ*CNT_W-1:0]     req_reps,
  output logic [NREQ-1:0]           req_ready,
  output logic [PAT_W-1:0]          gen_pattern,
  output logic                      gen_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   cur_id
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GUARD} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    sel_idx;
  logic             sel_found;
  logic [PAT_W-1:0] sel_pat;
  logic [CNT_W-1:0] sel_reps;
  logic [BW-1:0]    bit_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] reps_eff;
  logic [GW-1:0]    gap_cnt;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(idx);
      end
    end
  end

  assign sel_pat  = req_pattern[int'(sel_idx)*PAT_W +: PAT_W];
  assign sel_reps = req_reps[int'(sel_idx)*CNT_W +: CNT_W];

  // Gated by rst_n so a held request cannot show a grant while reset is asserted.
  assign req_ready = (rst_n && state == IDLE && sel_found) ? (NREQ'(1) << sel_idx) : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gen_pattern <= '0;
      gen_rst_n   <= 1'b0;
      done        <= 1'b0;
      cur_id      <= '0;
      bit_cnt     <= '0;
      rep_cnt     <= '0;
      reps_eff    <= '0;
      gap_cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_found) begin
            gen_pattern <= sel_pat;
            reps_eff    <= (sel_reps == '0) ? CNT_W'(1) : sel_reps;
            cur_id      <= sel_idx;
            ptr         <= (int'(sel_idx) == NREQ - 1) ? '0 : sel_idx + 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          gen_rst_n <= 1'b1;
          bit_cnt   <= '0;
          rep_cnt   <= '0;
          state     <= RUN;
        end
        RUN: begin
          if (int'(bit_cnt) == PAT_W - 1) begin
            bit_cnt <= '0;
            if (rep_cnt == reps_eff - 1'b1) begin
              gen_rst_n <= 1'b0;
              gap_cnt   <= '0;
              done      <= (GAP == 1);
              state     <= GUARD;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        GUARD: begin
          // done is registered, so it is raised one cycle ahead of the last guard cycle.
          if (int'(gap_cnt) == GAP - 1) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            done    <= (int'(gap_cnt) == GAP - 2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx_sched.sv
// tb/tb_pattern_tx_sched.sv - scoreboard bench for pattern_tx_sched
module tb_pattern_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_pattern;
  logic [15:0] req_reps;
  logic [3:0]  req_ready;
  logic [6:0]  gen_pattern;
  logic        gen_rst_n;
  logic        busy;
  logic        done;
  logic [1:0]  cur_id;

  pattern_tx_sched #(.NREQ(4), .PAT_W(7), .CNT_W(4), .GAP(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_pattern(req_pattern),
    .req_reps(req_reps), .req_ready(req_ready), .gen_pattern(gen_pattern),
    .gen_rst_n(gen_rst_n), .busy(busy), .done(done), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] rdy;
    logic [6:0] pat;
    int         r;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input logic [3:0] rdy, input logic [6:0] pat,
                      input int r, input bit b2b);
    exp_t e;
    e.id = id; e.rdy = rdy; e.pat = pat; e.r = r; e.b2b = b2b;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expectation per grant and tracks the job timeline.
  exp_t cur;
  bit   active = 1'b0;
  int   t_grant = 0;
  int   hi_cnt = 0;
  int   last_done = -100;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
    end else begin
      if (req_ready != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", int'(req_ready), 0);
        end else begin
          cur = exp_q.pop_front();
          check("grant_onehot", int'(req_ready), int'(cur.rdy));
          check("busy_at_grant", int'(busy), 0);
          if (cur.b2b) check("grant_after_done", cyc - last_done, 1);
          active  = 1'b1;
          t_grant = cyc;
          hi_cnt  = 0;
        end
      end
      if (active && cyc == t_grant + 1) begin
        check("gen_pattern", int'(gen_pattern), int'(cur.pat));
        check("cur_id", int'(cur_id), cur.id);
        check("busy_after_grant", int'(busy), 1);
      end
      if (gen_rst_n) begin
        hi_cnt++;
        if (active && hi_cnt == 1) check("run_start", cyc - t_grant, 2);
      end
      if (done) begin
        if (!active) begin
          check("unexpected_done", int'(done), 0);
        end else begin
          check("done_offset", cyc - t_grant, 1 + 7 * cur.r + 3);
          check("run_length", hi_cnt, 7 * cur.r);
          check("busy_at_done", int'(busy), 1);
        end
        active    = 1'b0;
        last_done = cyc;
      end
    end
  end

  task automatic wait_grant(input int i);
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[i]) seen = 1'b1;
    end
    check("grant_wait", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_wait", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_gen_pattern", int'(gen_pattern), 0);
    check("rst_gen_rst_n", int'(gen_rst_n), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cur_id", int'(cur_id), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    req_valid   = 4'b0000;
    req_pattern = '0;
    req_reps    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Single requester, reps 2.
    req_pattern[6:0] = 7'b1001011;
    req_reps[3:0]    = 4'd2;
    push(0, 4'b0001, 7'b1001011, 2, 1'b0);
    req_valid = 4'b0001;
    wait_grant(0);
    req_valid[0] = 1'b0;
    wait_done();
    repeat (2) @(posedge clk);
    #1;

    // Reset while idle with a held pattern restores ptr to 0.
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four held valid, reps 1.
    req_pattern = {7'h70, 7'h0F, 7'h2A, 7'h55};
    req_reps    = {4'd1, 4'd1, 4'd1, 4'd1};
    push(0, 4'b0001, 7'h55, 1, 1'b0);
    push(1, 4'b0010, 7'h2A, 1, 1'b1);
    push(2, 4'b0100, 7'h0F, 1, 1'b1);
    push(3, 4'b1000, 7'h70, 1, 1'b1);
    push(0, 4'b0001, 7'h55, 1, 1'b1);
    req_valid = 4'b1111;
    wait_grant(0);
    wait_grant(1);
    wait_grant(2);
    wait_grant(3);
    wait_grant(0);
    req_valid = 4'b0000;
    wait_done();
    repeat (2) @(posedge clk);
    #1;

    // Pointer wrap: ptr is 1, so 1 then 3 then 0.
    push(1, 4'b0010, 7'h2A, 1, 1'b0);
    push(3, 4'b1000, 7'h70, 1, 1'b1);
    push(0, 4'b0001, 7'h55, 1, 1'b1);
    req_valid = 4'b1011;
    wait_grant(1);
    req_valid[1] = 1'b0;
    wait_grant(3);
    req_valid[3] = 1'b0;
    wait_grant(0);
    req_valid[0] = 1'b0;
    wait_done();
    repeat (2) @(posedge clk);
    #1;

    // reps 0 behaves as 1.
    req_reps[11:8] = 4'd0;
    push(2, 4'b0100, 7'h0F, 1, 1'b0);
    req_valid = 4'b0100;
    wait_grant(2);
    req_valid[2] = 1'b0;
    wait_done();
    repeat (2) @(posedge clk);
    #1;

    // Abort a reps 3 job on requester 1 at T+5; ptr would favour 2 without the reset.
    req_reps[7:4] = 4'd3;
    push(1, 4'b0010, 7'h2A, 3, 1'b0);
    req_valid = 4'b0010;
    wait_grant(1);
    req_valid[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n          = 1'b0;
    req_reps[3:0]  = 4'd1;
    req_reps[11:8] = 4'd1;
    req_valid      = 4'b0101;
    #1;
    check_reset_outputs();
    push(0, 4'b0001, 7'h55, 1, 1'b0);
    push(2, 4'b0100, 7'h0F, 1, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_grant(0);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_grant(2);
    req_valid[2] = 1'b0;
    wait_done();
    repeat (20) @(posedge clk);
    #1;

    check("expect_queue_empty", exp_q.size(), 0);
    check("no_job_in_flight", int'(active), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
